seq_pattern_ctrl: RTL and testbench
===================================

// Module: seq_pattern_ctrl
// PURPOSE
//  Programmable sequencer for multi-input pattern detection, replacing hard-coded
//  detector FSMs. Holds a step table of (mask, value) pairs over in_vec, steps through
//  it with the codebase's advance / hold / fall-back-to-first-step rule, and reports
//  match, fail and timeout. Configured over a write port while idle; armed by a pulse.
// PARAMETERS
//  NUM_IN     4   width of in_vec (detector inputs i1..iN, i1 = bit 0)
//  STEP_W     4   step index width; table depth = 2**STEP_W
//  TMO_W      16  dwell/timeout counter width
//  AUTO_REARM 0   1: return to step 0 and keep running after a match; 0: go idle
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          async, active-low reset
//  cfg_we     in   1          table write strobe, honoured only when busy=0
//  cfg_addr   in   STEP_W     table entry written
//  cfg_mask   in   NUM_IN     care bits for entry (1 = compare)
//  cfg_val    in   NUM_IN     required values for cared bits
//  last_idx   in   STEP_W     index of final step, sampled on arm
//  tmo_limit  in   TMO_W      max dwell cycles per step >0; 0 disables; sampled on arm
//  arm        in   1          one-cycle start pulse
//  in_vec     in   NUM_IN     monitored inputs, synchronous to clk
//  busy       out  1          1 while RUN
//  step_idx   out  STEP_W     current step
//  match      out  1          1-cycle pulse: final step hit
//  fail       out  1          1-cycle pulse: sequence broken at step >0
//  timeout    out  1          1-cycle pulse: dwell limit reached
//  cfg_err    out  1          1-cycle pulse: cfg_we while busy (write dropped)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, table masks/values 0, counters 0.
//  hit(k) = ((in_vec ^ val[k]) & mask[k]) == 0; mask=0 always hits.
//  States: IDLE, RUN. All outputs registered; response appears the cycle after the
//  clk edge sampling in_vec.
//  IDLE: cfg_we writes table[cfg_addr]. arm -> RUN, step=0, dwell=0, latch
//   last_idx/tmo_limit. Simultaneous cfg_we+arm: write completes, then arm takes effect
//   (new entry used).
//  RUN, per cycle, first matching rule wins:
//   1 hit(step) & step==last: match=1; step=0; AUTO_REARM ? stay RUN : IDLE.
//   2 hit(step): step+1, dwell=0.
//   3 step>0 & hit(step-1): hold; dwell+1; dwell+1==tmo_limit (limit!=0) ->
//     timeout=1, step=0, dwell=0, stay RUN.
//   4 step==0: wait at 0, no pulse, dwell not counted.
//   5 else: fail=1, step=0, dwell=0 (no same-cycle re-check of step 0).
//  arm during RUN: restart at step 0, re-latch last_idx/tmo_limit; no pulses.
//  cfg_we during RUN: table unchanged, cfg_err=1.
//  last_idx=0: any hit(0) matches immediately (single-step pattern).
//  Dwell saturates at all-ones; no wrap.
//  Async reset mid-RUN: immediate return to reset values, pending pulses dropped.
// TESTING
//  1 Program 3 steps {m=F,v=4},{m=F,v=9},{m=F,v=0}, last=2, arm; drive 4,9,0 ->
//    step_idx 0,1,2, match high 1 cycle after the 0 sample; busy drops same cycle.
//  2 Same table; drive 4,4,4,9,9,0 -> holds at step1 then step2, match once, no fail.
//  3 Same table; drive 4,9,7 -> fail pulse after 7, step_idx=0, busy stays 1.
//  4 tmo_limit=3; drive 4 then 4,4,4 -> timeout on the third hold, step_idx=0.
//  5 cfg_we during RUN -> cfg_err=1, later readback run shows old entry; AUTO_REARM=1:
//    two back-to-back patterns give two match pulses with busy held 1.
//  6 Assert reset low at step 2 -> busy=0, step_idx=0, no match; masks=0 after reset
//    make any in_vec hit (arm, last=0 -> match next cycle).

Source files
------------

// File: rtl/seq_pattern_ctrl.sv
// Programmable multi-input pattern sequencer: a (mask, value) step table walked with
// advance / hold / fall-back rules, reporting match, fail and timeout pulses.
module seq_pattern_ctrl #(
    parameter int NUM_IN     = 4,
    parameter int STEP_W     = 4,
    parameter int TMO_W      = 16,
    parameter bit AUTO_REARM = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [STEP_W-1:0] cfg_addr,
    input  logic [NUM_IN-1:0] cfg_mask,
    input  logic [NUM_IN-1:0] cfg_val,
    input  logic [STEP_W-1:0] last_idx,
    input  logic [TMO_W-1:0]  tmo_limit,
    input  logic              arm,
    input  logic [NUM_IN-1:0] in_vec,
    output logic              busy,
    output logic [STEP_W-1:0] step_idx,
    output logic              match,
    output logic              fail,
    output logic              timeout,
    output logic              cfg_err
);
    localparam int DEPTH = 1 << STEP_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_IN-1:0] mask_q [DEPTH];
    logic [NUM_IN-1:0] val_q  [DEPTH];
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] last_q, last_d;
    logic [TMO_W-1:0]  dwell_q, dwell_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              match_q, match_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic              cfg_err_q, cfg_err_d;

    logic              tbl_we;
    logic [STEP_W-1:0] prev_idx;
    logic              hit_cur;
    logic              hit_prev;
    logic [TMO_W:0]    dwell_inc;

    assign tbl_we    = cfg_we && (state_q == S_IDLE);
    assign prev_idx  = step_q - 1'b1;
    assign hit_cur   = ((in_vec ^ val_q[step_q]) & mask_q[step_q]) == '0;
    assign hit_prev  = ((in_vec ^ val_q[prev_idx]) & mask_q[prev_idx]) == '0;
    // One extra bit so a saturated dwell never aliases onto a small limit.
    assign dwell_inc = {1'b0, dwell_q} + 1'b1;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        last_d    = last_q;
        dwell_d   = dwell_q;
        tmo_d     = tmo_q;
        match_d   = 1'b0;
        fail_d    = 1'b0;
        timeout_d = 1'b0;
        cfg_err_d = cfg_we && (state_q == S_RUN);

        if (arm) begin
            // Arm (re)starts from step 0 regardless of state and suppresses pulses.
            state_d = S_RUN;
            step_d  = '0;
            dwell_d = '0;
            last_d  = last_idx;
            tmo_d   = tmo_limit;
        end else if (state_q == S_RUN) begin
            if (hit_cur && (step_q == last_q)) begin
                match_d = 1'b1;
                step_d  = '0;
                dwell_d = '0;
                if (!AUTO_REARM) state_d = S_IDLE;
            end else if (hit_cur) begin
                step_d  = step_q + 1'b1;
                dwell_d = '0;
            end else if ((step_q != '0) && hit_prev) begin
                if ((tmo_q != '0) && (dwell_inc == {1'b0, tmo_q})) begin
                    timeout_d = 1'b1;
                    step_d    = '0;
                    dwell_d   = '0;
                end else if (!(&dwell_q)) begin
                    dwell_d = dwell_inc[TMO_W-1:0];
                end
            end else if (step_q != '0) begin
                // Step 0 is not re-checked this cycle; the next cycle evaluates it.
                fail_d  = 1'b1;
                step_d  = '0;
                dwell_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            last_q    <= '0;
            dwell_q   <= '0;
            tmo_q     <= '0;
            match_q   <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            last_q    <= last_d;
            dwell_q   <= dwell_d;
            tmo_q     <= tmo_d;
            match_q   <= match_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
                val_q[i]  <= '0;
            end
        end else if (tbl_we) begin
            mask_q[cfg_addr] <= cfg_mask;
            val_q[cfg_addr]  <= cfg_val;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign step_idx = step_q;
    assign match    = match_q;
    assign fail     = fail_q;
    assign timeout  = timeout_q;
    assign cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Scenario bench for seq_pattern_ctrl: one DUT without auto-rearm, one with, sharing
// configuration and inputs; expected outputs queued per driven cycle and compared after.
module tb_seq_pattern_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [3:0]  cfg_mask = '0;
  logic [3:0]  cfg_val = '0;
  logic [3:0]  last_idx = '0;
  logic [15:0] tmo_limit = '0;
  logic        arm = 1'b0;
  logic        arm2 = 1'b0;
  logic [3:0]  in_vec = '0;

  logic        busy, match, fail, timeout, cfg_err;
  logic [3:0]  step_idx;
  logic        busy2, match2, fail2, timeout2, cfg_err2;
  logic [3:0]  step_idx2;

  // {busy, step_idx, match, fail, timeout, cfg_err}
  wire  [8:0]  obs  = {busy, step_idx, match, fail, timeout, cfg_err};
  wire  [8:0]  obs2 = {busy2, step_idx2, match2, fail2, timeout2, cfg_err2};

  logic [8:0]  exp_q[$];
  logic [8:0]  exp_w;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  seq_pattern_ctrl #(.NUM_IN(4), .STEP_W(4), .TMO_W(16), .AUTO_REARM(1'b0)) u_dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mask(cfg_mask), .cfg_val(cfg_val), .last_idx(last_idx),
    .tmo_limit(tmo_limit), .arm(arm), .in_vec(in_vec), .busy(busy),
    .step_idx(step_idx), .match(match), .fail(fail), .timeout(timeout),
    .cfg_err(cfg_err)
  );

  seq_pattern_ctrl #(.NUM_IN(4), .STEP_W(4), .TMO_W(16), .AUTO_REARM(1'b1)) u_dut_rearm (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mask(cfg_mask), .cfg_val(cfg_val), .last_idx(last_idx),
    .tmo_limit(tmo_limit), .arm(arm2), .in_vec(in_vec), .busy(busy2),
    .step_idx(step_idx2), .match(match2), .fail(fail2), .timeout(timeout2),
    .cfg_err(cfg_err2)
  );

  function automatic logic [8:0] pk(bit b, int s, bit m, bit f, bit t, bit c);
    logic [3:0] s4;
    s4 = s[3:0];
    return {b, s4, m, f, t, c};
  endfunction

  // Driver tasks: every input change happens 1 time unit after a rising edge.
  task automatic write_entry(int a, int m, int v);
    cfg_addr = a[3:0]; cfg_mask = m[3:0]; cfg_val = v[3:0]; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_arm(int last, int tmo);
    last_idx = last[3:0]; tmo_limit = tmo[15:0]; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic program_base();
    write_entry(0, 15, 4);
    write_entry(1, 15, 9);
    write_entry(2, 15, 0);
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (obs !== 9'h000 || obs2 !== 9'h000) begin
      n_errors++;
      $display("FAIL reset got %h/%h exp 000", obs, obs2);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int         vq[$];
    logic [8:0] eq[$];
    program_base();
    do_arm(2, 0);
    n_checks++;
    if (obs !== pk(1, 0, 0, 0, 0, 0)) begin
      n_errors++; $display("FAIL basic_arm got %h exp %h", obs, pk(1, 0, 0, 0, 0, 0));
    end
    vq = '{4, 9, 0, 0};
    eq = '{pk(1, 1, 0, 0, 0, 0), pk(1, 2, 0, 0, 0, 0), pk(0, 0, 1, 0, 0, 0), pk(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < vq.size(); i++) begin
      in_vec = vq[i][3:0]; exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      exp_w = exp_q.pop_front(); n_checks++;
      if (obs !== exp_w) begin
        n_errors++; $display("FAIL basic[%0d] got %h exp %h", i, obs, exp_w);
      end
    end
  endtask

  task automatic test_hold();
    int         vq[$];
    logic [8:0] eq[$];
    do_arm(2, 0);
    vq = '{4, 4, 4, 9, 9, 0, 0};
    eq = '{pk(1, 1, 0, 0, 0, 0), pk(1, 1, 0, 0, 0, 0), pk(1, 1, 0, 0, 0, 0), pk(1, 2, 0, 0, 0, 0),
           pk(1, 2, 0, 0, 0, 0), pk(0, 0, 1, 0, 0, 0), pk(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < vq.size(); i++) begin
      in_vec = vq[i][3:0]; exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      exp_w = exp_q.pop_front(); n_checks++;
      if (obs !== exp_w) begin
        n_errors++; $display("FAIL hold[%0d] got %h exp %h", i, obs, exp_w);
      end
    end
  endtask

  task automatic test_fail();
    int         vq[$];
    logic [8:0] eq[$];
    do_arm(2, 0);
    vq = '{4, 9, 7, 5};
    eq = '{pk(1, 1, 0, 0, 0, 0), pk(1, 2, 0, 0, 0, 0), pk(1, 0, 0, 1, 0, 0), pk(1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < vq.size(); i++) begin
      in_vec = vq[i][3:0]; exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      exp_w = exp_q.pop_front(); n_checks++;
      if (obs !== exp_w) begin
        n_errors++; $display("FAIL fail_seq[%0d] got %h exp %h", i, obs, exp_w);
      end
    end
  endtask

  task automatic test_timeout();
    int         vq[$];
    logic [8:0] eq[$];
    do_arm(2, 3);
    n_checks++;
    if (obs !== pk(1, 0, 0, 0, 0, 0)) begin
      n_errors++; $display("FAIL rearm_run got %h exp %h", obs, pk(1, 0, 0, 0, 0, 0));
    end
    vq = '{4, 4, 4, 4, 4, 7};
    eq = '{pk(1, 1, 0, 0, 0, 0), pk(1, 1, 0, 0, 0, 0), pk(1, 1, 0, 0, 0, 0), pk(1, 0, 0, 0, 1, 0),
           pk(1, 1, 0, 0, 0, 0), pk(1, 0, 0, 1, 0, 0)};
    for (int i = 0; i < vq.size(); i++) begin
      in_vec = vq[i][3:0]; exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      exp_w = exp_q.pop_front(); n_checks++;
      if (obs !== exp_w) begin
        n_errors++; $display("FAIL timeout[%0d] got %h exp %h", i, obs, exp_w);
      end
    end
  endtask

  task automatic test_cfg_err();
    int         vq[$];
    logic [8:0] eq[$];
    in_vec = 4'h7;
    write_entry(1, 15, 3);
    n_checks++;
    if (obs !== pk(1, 0, 0, 0, 0, 1)) begin
      n_errors++; $display("FAIL cfg_err got %h exp %h", obs, pk(1, 0, 0, 0, 0, 1));
    end
    do_arm(2, 0);
    vq = '{7, 4, 9, 0};
    eq = '{pk(1, 0, 0, 0, 0, 0), pk(1, 1, 0, 0, 0, 0), pk(1, 2, 0, 0, 0, 0), pk(0, 0, 1, 0, 0, 0)};
    for (int i = 0; i < vq.size(); i++) begin
      in_vec = vq[i][3:0]; exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      exp_w = exp_q.pop_front(); n_checks++;
      if (obs !== exp_w) begin
        n_errors++; $display("FAIL cfg_readback[%0d] got %h exp %h", i, obs, exp_w);
      end
    end
  endtask

  task automatic test_write_with_arm();
    cfg_addr = 4'h0; cfg_mask = 4'hF; cfg_val = 4'hA; cfg_we = 1'b1;
    last_idx = 4'h0; tmo_limit = 16'h0; arm = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; arm = 1'b0;
    n_checks++;
    if (obs !== pk(1, 0, 0, 0, 0, 0)) begin
      n_errors++; $display("FAIL we_arm got %h exp %h", obs, pk(1, 0, 0, 0, 0, 0));
    end
    in_vec = 4'hA; exp_q.push_back(pk(0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    exp_w = exp_q.pop_front(); n_checks++;
    if (obs !== exp_w) begin
      n_errors++; $display("FAIL we_arm_match got %h exp %h", obs, exp_w);
    end
    program_base();
  endtask

  task automatic test_back_to_back();
    int         vq[$];
    logic [8:0] eq[$];
    last_idx = 4'h2; tmo_limit = 16'h0; arm2 = 1'b1;
    @(posedge clk); #1;
    arm2 = 1'b0;
    vq = '{4, 9, 0, 4, 9, 0, 7};
    eq = '{pk(1, 1, 0, 0, 0, 0), pk(1, 2, 0, 0, 0, 0), pk(1, 0, 1, 0, 0, 0), pk(1, 1, 0, 0, 0, 0),
           pk(1, 2, 0, 0, 0, 0), pk(1, 0, 1, 0, 0, 0), pk(1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < vq.size(); i++) begin
      in_vec = vq[i][3:0]; exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      exp_w = exp_q.pop_front(); n_checks++;
      if (obs2 !== exp_w) begin
        n_errors++; $display("FAIL rearm[%0d] got %h exp %h", i, obs2, exp_w);
      end
    end
  endtask

  task automatic test_async_reset();
    int         vq[$];
    logic [8:0] eq[$];
    do_arm(2, 0);
    vq = '{4, 9};
    eq = '{pk(1, 1, 0, 0, 0, 0), pk(1, 2, 0, 0, 0, 0)};
    for (int i = 0; i < vq.size(); i++) begin
      in_vec = vq[i][3:0]; exp_q.push_back(eq[i]);
      @(posedge clk); #1;
      exp_w = exp_q.pop_front(); n_checks++;
      if (obs !== exp_w) begin
        n_errors++; $display("FAIL pre_reset[%0d] got %h exp %h", i, obs, exp_w);
      end
    end
    in_vec = 4'h0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 9'h000 || obs2 !== 9'h000) begin
      n_errors++; $display("FAIL async_reset got %h/%h exp 000", obs, obs2);
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 9'h000) begin
      n_errors++; $display("FAIL reset_hold got %h exp 000", obs);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 9'h000) begin
      n_errors++; $display("FAIL post_reset got %h exp 000", obs);
    end
    in_vec = 4'h5;
    do_arm(0, 0);
    exp_q.push_back(pk(0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    exp_w = exp_q.pop_front(); n_checks++;
    if (obs !== exp_w) begin
      n_errors++; $display("FAIL zero_mask_match got %h exp %h", obs, exp_w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_fail();
    test_timeout();
    test_cfg_err();
    test_write_with_arm();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
